sampler_dma_regs_arb: RTL and testbench

- Next-generation sampler DMA register block: a CPU-visible register file holding per-voice DMA descriptors, plus a round-robin arbiter.
- The arbiter turns CPU start/stop writes into a serialized valid/ready command stream for the DMA engine.
- The engine's completion events are tracked in per-voice status bits.
- Sits between the AXI-lite register slave and the sampler DMA engine.

---
 rtl/sampler_dma_regs_arb_if.sv | 37 +++
 rtl/sampler_dma_regs_arb.sv | 219 +++++++++++++++++++++
 tb/tb_sampler_dma_regs_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sampler_dma_regs_arb_if.sv
// CPU register bus plus the DMA command/done stream between the register block and the engine.
interface sampler_dma_regs_arb_if #(
  parameter int unsigned NUM_VOICES = 16,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LEN_W      = 24
);
  localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [31:0]       data_in;
  logic [ADDR_W-1:0] reg_addr_wr;
  logic              data_wren;
  logic [ADDR_W-1:0] reg_addr_rd;
  logic              rd_en;
  logic [31:0]       data_out;
  logic              rd_valid;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [VW-1:0]     cmd_voice;
  logic              cmd_start;
  logic [31:0]       cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_loop;

  logic              done_valid;
  logic [VW-1:0]     done_voice;

  modport slave (
    input  data_in, reg_addr_wr, data_wren, reg_addr_rd, rd_en, cmd_ready, done_valid, done_voice,
    output data_out, rd_valid, cmd_valid, cmd_voice, cmd_start, cmd_addr, cmd_len, cmd_loop
  );

  modport master (
    output data_in, reg_addr_wr, data_wren, reg_addr_rd, rd_en, cmd_ready, done_valid, done_voice,
    input  data_out, rd_valid, cmd_valid, cmd_voice, cmd_start, cmd_addr, cmd_len, cmd_loop
  );
endinterface

// File: rtl/sampler_dma_regs_arb.sv
// Sampler DMA register file with a round-robin start/stop command arbiter.
// Optional macro SAMPLER_DMA_IRQ_EN adds IRQ_MASK at 0x005 and a registered irq output.
module sampler_dma_regs_arb #(
  parameter int unsigned NUM_VOICES = 16,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LEN_W      = 24,
  parameter logic [31:0] VERSION    = 32'h0002_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  sampler_dma_regs_arb_if.slave bus,
  output logic                 irq
);
  localparam int unsigned VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [31:0] VoiceBase = 32'h0000_0100;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  logic [31:0]           base_q [NUM_VOICES];
  logic [LEN_W-1:0]      len_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] loop_q;
  logic                  enable_q;
  logic [NUM_VOICES-1:0] pend_start_q, pend_start_d, pend_stop_q, pend_stop_d;
  logic [NUM_VOICES-1:0] busy_q, busy_d, done_q, done_d, pend_any;
  logic [31:0]           data_out_q, rd_data, pend_cnt;
  logic                  rd_valid_q;

  state_e                state_q;
  logic [VW-1:0]         rr_q, cmd_voice_q, sel_voice, idx_v;
  logic                  sel_found, cmd_valid_q, cmd_start_q, cmd_loop_q, hs;
  logic [31:0]           cmd_addr_q;
  logic [LEN_W-1:0]      cmd_len_q;

`ifdef SAMPLER_DMA_IRQ_EN
  logic [NUM_VOICES-1:0] irq_mask_q;
  logic                  irq_q;
`endif

  // Address decode: voice v occupies words 0x100+4v .. 0x100+4v+3.
  logic [31:0]   wa, ra;
  logic          wr_voice_hit, rd_voice_hit, wr_gctrl, wr_ctrl, wr_status;
  logic [VW-1:0] wv, rv;
  logic [1:0]    wr_r, rd_r;

  assign wa           = 32'(bus.reg_addr_wr);
  assign ra           = 32'(bus.reg_addr_rd);
  assign wr_voice_hit = (wa >= VoiceBase) && (((wa - VoiceBase) >> 2) < NUM_VOICES);
  assign rd_voice_hit = (ra >= VoiceBase) && (((ra - VoiceBase) >> 2) < NUM_VOICES);
  assign wv           = VW'((wa - VoiceBase) >> 2);
  assign rv           = VW'((ra - VoiceBase) >> 2);
  assign wr_r         = wa[1:0];
  assign rd_r         = ra[1:0];
  assign wr_gctrl     = bus.data_wren && (wa == 32'h3);
  assign wr_ctrl      = bus.data_wren && wr_voice_hit && (wr_r == 2'd2);
  assign wr_status    = bus.data_wren && wr_voice_hit && (wr_r == 2'd3);

  assign pend_any = pend_start_q | pend_stop_q;
  assign pend_cnt = 32'($countones(pend_any));
  assign hs       = cmd_valid_q && bus.cmd_ready;

  always_comb begin
    rd_data = 32'hDEAD_DEAD;
    if (rd_voice_hit) begin
      case (rd_r)
        2'd0:    rd_data = base_q[rv];
        2'd1:    rd_data = 32'(len_q[rv]);
        2'd2:    rd_data = {29'd0, loop_q[rv], 2'b00};
        default: rd_data = {28'd0, pend_stop_q[rv], pend_start_q[rv], done_q[rv], busy_q[rv]};
      endcase
    end else begin
      case (ra)
        32'h0:   rd_data = VERSION;
        32'h1:   rd_data = 32'(NUM_VOICES);
        32'h2:   rd_data = VoiceBase;
        32'h3:   rd_data = {31'd0, enable_q};
        32'h4:   rd_data = pend_cnt;
`ifdef SAMPLER_DMA_IRQ_EN
        32'h5:   rd_data = 32'(irq_mask_q);
`endif
        default: rd_data = 32'hDEAD_DEAD;
      endcase
    end
  end

  // Ordering below encodes the collision rules: later assignments win.
  always_comb begin
    pend_start_d = pend_start_q;
    pend_stop_d  = pend_stop_q;
    busy_d       = busy_q;
    done_d       = done_q;
    if (hs) begin
      if (cmd_start_q) pend_start_d[cmd_voice_q] = 1'b0;
      else             pend_stop_d[cmd_voice_q]  = 1'b0;
    end
    if (bus.done_valid) busy_d[bus.done_voice] = 1'b0;
    if (hs && cmd_start_q) busy_d[cmd_voice_q] = 1'b1;
    if (wr_gctrl && bus.data_in[1]) begin
      pend_stop_d  = pend_stop_d | busy_q;
      pend_start_d = '0;
    end
    if (wr_ctrl) begin
      if (bus.data_in[1]) begin
        pend_stop_d[wv]  = 1'b1;
        pend_start_d[wv] = 1'b0;
      end else if (bus.data_in[0]) begin
        pend_start_d[wv] = 1'b1;
        pend_stop_d[wv]  = 1'b0;
      end
    end
    if (wr_status && bus.data_in[1]) done_d[wv] = 1'b0;
    if (bus.done_valid) done_d[bus.done_voice] = 1'b1;
  end

  // First pending voice at or after the round-robin pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_voice = '0;
    idx_v     = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      idx_v = VW'((32'(rr_q) + i) % NUM_VOICES);
      if (!sel_found && pend_any[idx_v]) begin
        sel_found = 1'b1;
        sel_voice = idx_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
      end
      loop_q       <= '0;
      enable_q     <= 1'b0;
      pend_start_q <= '0;
      pend_stop_q  <= '0;
      busy_q       <= '0;
      done_q       <= '0;
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      pend_start_q <= pend_start_d;
      pend_stop_q  <= pend_stop_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_valid_q   <= bus.rd_en;
      if (bus.rd_en) data_out_q <= rd_data;
      if (wr_gctrl) enable_q <= bus.data_in[0];
      if (bus.data_wren && wr_voice_hit) begin
        case (wr_r)
          2'd0:    base_q[wv] <= bus.data_in;
          2'd1:    len_q[wv]  <= bus.data_in[LEN_W-1:0];
          2'd2:    loop_q[wv] <= bus.data_in[2];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_voice_q <= '0;
      cmd_start_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_loop_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable_q && sel_found) begin
            state_q     <= StIssue;
            cmd_valid_q <= 1'b1;
            cmd_voice_q <= sel_voice;
            cmd_start_q <= ~pend_stop_q[sel_voice];
            cmd_addr_q  <= base_q[sel_voice];
            cmd_len_q   <= len_q[sel_voice];
            cmd_loop_q  <= loop_q[sel_voice];
          end
        end
        StIssue: begin
          if (bus.cmd_ready) begin
            state_q     <= StIdle;
            cmd_valid_q <= 1'b0;
            rr_q        <= (cmd_voice_q == VW'(NUM_VOICES - 1)) ? '0 : cmd_voice_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SAMPLER_DMA_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (bus.data_wren && (wa == 32'h5)) irq_mask_q <= NUM_VOICES'(bus.data_in);
      irq_q <= |(done_q & irq_mask_q);
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign bus.data_out  = data_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_voice = cmd_voice_q;
  assign bus.cmd_start = cmd_start_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_len   = cmd_len_q;
  assign bus.cmd_loop  = cmd_loop_q;
endmodule

// File: tb/tb_sampler_dma_regs_arb.sv
// Scoreboard bench for sampler_dma_regs_arb: register reads and DMA commands checked against queues.
module tb_sampler_dma_regs_arb;
  localparam int unsigned NV = 16;
`ifdef SAMPLER_DMA_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  voice;
    logic        start;
    logic [31:0] addr;
    logic [23:0] len;
    logic        loop;
  } cmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  int   n_cmp = 0;
  int   n_fail = 0;

  cmd_t        exp_cmd_q[$];
  logic [31:0] exp_rd_q[$];

  sampler_dma_regs_arb_if #(.NUM_VOICES(NV), .ADDR_W(10), .LEN_W(24)) bus ();

  sampler_dma_regs_arb #(
    .NUM_VOICES(NV), .ADDR_W(10), .LEN_W(24), .VERSION(32'h0002_0000)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic cpu_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.reg_addr_wr = a;
    bus.data_in     = d;
    bus.data_wren   = 1'b1;
    @(negedge clk);
    bus.data_wren   = 1'b0;
  endtask

  task automatic cpu_read(input logic [9:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    bus.reg_addr_rd = a;
    bus.rd_en       = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.data_out;
    v = bus.rd_valid;
  endtask

  task automatic wait_cmd(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.cmd_valid) seen = 1'b1;
    end
  endtask

  task automatic accept_cmd();
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
  endtask

  function automatic cmd_t cur_cmd();
    return {bus.cmd_voice, bus.cmd_start, bus.cmd_addr, bus.cmd_len, bus.cmd_loop};
  endfunction

  task automatic test_reset();
    logic [9:0]  ra[9];
    logic [31:0] re[9];
    logic [31:0] d, e;
    logic        v;
    bus.data_in = '0; bus.reg_addr_wr = '0; bus.data_wren = 1'b0;
    bus.reg_addr_rd = '0; bus.rd_en = 1'b0; bus.cmd_ready = 1'b0;
    bus.done_valid = 1'b0; bus.done_voice = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.data_out !== 32'h0) begin n_fail++;
      $display("FAIL reset_data_out: got %h exp 0", bus.data_out); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_rd_valid: got %b exp 0", bus.rd_valid); end
    n_cmp++; if (bus.cmd_valid !== 1'b0 || cur_cmd() !== '0) begin n_fail++;
      $display("FAIL reset_cmd: valid %b cmd %h exp 0/0", bus.cmd_valid, cur_cmd()); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b exp 0", irq); end
    reset = 1'b0;
    ra = '{10'h000, 10'h001, 10'h002, 10'h3FF, 10'h003, 10'h004, 10'h005, 10'h10F, 10'h140};
    re = '{32'h0002_0000, 32'd16, 32'h100, 32'hDEAD_DEAD, 32'h0, 32'h0,
           IrqEn ? 32'h0 : 32'hDEAD_DEAD, 32'h0, 32'hDEAD_DEAD};
    foreach (ra[i]) exp_rd_q.push_back(re[i]);
    foreach (ra[i]) begin
      cpu_read(ra[i], d, v);
      e = exp_rd_q.pop_front();
      n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
        $display("FAIL reset_read[%h]: got %h valid %b exp %h", ra[i], d, v, e); end
    end
    @(negedge clk);
    n_cmp++; if (bus.rd_valid !== 1'b0 || bus.data_out !== 32'hDEAD_DEAD) begin n_fail++;
      $display("FAIL read_hold: valid %b data %h exp 0/DEADDEAD", bus.rd_valid, bus.data_out); end
  endtask

  task automatic test_single_start();
    logic [9:0]  ra[4];
    logic [31:0] re[4];
    logic [31:0] d, e;
    logic        v, seen;
    cmd_t        ec;
    cpu_write(10'h10C, 32'h1000_0000);
    cpu_write(10'h10D, 32'h0000_0400);
    cpu_write(10'h10E, 32'h5);
    ra = '{10'h10F, 10'h004, 10'h10E, 10'h10D};
    re = '{32'h4, 32'h1, 32'h4, 32'h400};
    foreach (ra[i]) exp_rd_q.push_back(re[i]);
    foreach (ra[i]) begin
      cpu_read(ra[i], d, v);
      e = exp_rd_q.pop_front();
      n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
        $display("FAIL start_pre[%h]: got %h valid %b exp %h", ra[i], d, v, e); end
    end
    exp_cmd_q.push_back('{voice: 4'd3, start: 1'b1, addr: 32'h1000_0000, len: 24'h400, loop: 1'b1});
    cpu_write(10'h003, 32'h1);
    wait_cmd(seen);
    ec = exp_cmd_q.pop_front();
    n_cmp++; if (!seen || cur_cmd() !== ec) begin n_fail++;
      $display("FAIL start_cmd: seen %b got %h exp %h", seen, cur_cmd(), ec); end
    accept_cmd();
    cpu_write(10'h10D, 32'hFFFF_FFFF);
    ra = '{10'h10F, 10'h004, 10'h003, 10'h10D};
    re = '{32'h1, 32'h0, 32'h1, 32'h00FF_FFFF};
    foreach (ra[i]) exp_rd_q.push_back(re[i]);
    foreach (ra[i]) begin
      cpu_read(ra[i], d, v);
      e = exp_rd_q.pop_front();
      n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
        $display("FAIL start_post[%h]: got %h valid %b exp %h", ra[i], d, v, e); end
    end
  endtask

  task automatic test_rr_wrap();
    logic [31:0] d;
    logic        v, seen;
    cmd_t        ec;
    cpu_write(10'h003, 32'h0);
    cpu_write(10'h13A, 32'h1);
    exp_cmd_q.push_back('{voice: 4'd14, start: 1'b1, addr: 32'h0, len: 24'h0, loop: 1'b0});
    cpu_write(10'h003, 32'h1);
    wait_cmd(seen);
    ec = exp_cmd_q.pop_front();
    n_cmp++; if (!seen || cur_cmd() !== ec) begin n_fail++;
      $display("FAIL rr_v14: seen %b got %h exp %h", seen, cur_cmd(), ec); end
    accept_cmd();
    cpu_write(10'h003, 32'h0);
    cpu_write(10'h13C, 32'hF000_0000); cpu_write(10'h13D, 32'h15);
    cpu_write(10'h100, 32'hA000_0000); cpu_write(10'h101, 32'h20);
    cpu_write(10'h104, 32'hB000_0000); cpu_write(10'h105, 32'h30);
    cpu_write(10'h106, 32'h1); cpu_write(10'h102, 32'h5); cpu_write(10'h13E, 32'h1);
    exp_cmd_q.push_back('{voice: 4'd15, start: 1'b1, addr: 32'hF000_0000, len: 24'h15, loop: 1'b0});
    exp_cmd_q.push_back('{voice: 4'd0, start: 1'b1, addr: 32'hA000_0000, len: 24'h20, loop: 1'b1});
    exp_cmd_q.push_back('{voice: 4'd1, start: 1'b1, addr: 32'hB000_0000, len: 24'h30, loop: 1'b0});
    cpu_write(10'h003, 32'h1);
    for (int n = 0; n < 3; n++) begin
      wait_cmd(seen);
      ec = exp_cmd_q.pop_front();
      n_cmp++; if (!seen || cur_cmd() !== ec) begin n_fail++;
        $display("FAIL rr_order[%0d]: seen %b got %h exp %h", n, seen, cur_cmd(), ec); end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        n_cmp++; if (bus.cmd_valid !== 1'b1 || cur_cmd() !== ec) begin n_fail++;
          $display("FAIL rr_stall[%0d.%0d]: valid %b got %h exp %h", n, k, bus.cmd_valid,
                   cur_cmd(), ec); end
      end
      accept_cmd();
    end
    exp_rd_q.push_back(32'h1);
    cpu_read(10'h13F, d, v);
    n_cmp++; if (v !== 1'b1 || d !== exp_rd_q[0]) begin n_fail++;
      $display("FAIL rr_status15: got %h exp %h", d, exp_rd_q[0]); end
    void'(exp_rd_q.pop_front());
  endtask

  task automatic test_stop_wins();
    logic [9:0]  wdat[3];
    logic [31:0] re[3];
    logic [31:0] d, e;
    logic        v, seen, extra;
    cmd_t        ec;
    cpu_write(10'h003, 32'h0);
    wdat = '{10'h1, 10'h2, 10'h3};
    re   = '{32'h4, 32'h8, 32'h8};
    foreach (wdat[i]) exp_rd_q.push_back(re[i]);
    foreach (wdat[i]) begin
      cpu_write(10'h10A, 32'(wdat[i]));
      cpu_read(10'h10B, d, v);
      e = exp_rd_q.pop_front();
      n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
        $display("FAIL stop_pend[ctrl=%0h]: got %h exp %h", wdat[i], d, e); end
    end
    exp_cmd_q.push_back('{voice: 4'd2, start: 1'b0, addr: 32'h0, len: 24'h0, loop: 1'b0});
    cpu_write(10'h003, 32'h1);
    wait_cmd(seen);
    ec = exp_cmd_q.pop_front();
    n_cmp++; if (!seen || cur_cmd() !== ec) begin n_fail++;
      $display("FAIL stop_cmd: seen %b got %h exp %h", seen, cur_cmd(), ec); end
    accept_cmd();
    extra = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.cmd_valid) extra = 1'b1; end
    n_cmp++; if (extra !== 1'b0) begin n_fail++;
      $display("FAIL stop_no_start: got cmd_valid %b exp 0", extra); end
    exp_rd_q.push_back(32'h0);
    cpu_read(10'h10B, d, v);
    e = exp_rd_q.pop_front();
    n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
      $display("FAIL stop_status2: got %h exp %h", d, e); end
  endtask

  task automatic test_stop_all();
    logic [9:0]  ra[3];
    logic [31:0] re[3];
    logic [31:0] d, e;
    logic        v, seen;
    cmd_t        ec;
    cpu_write(10'h003, 32'h2);
    ra = '{10'h003, 10'h004, 10'h10F};
    re = '{32'h0, 32'h5, 32'h9};
    foreach (ra[i]) exp_rd_q.push_back(re[i]);
    foreach (ra[i]) begin
      cpu_read(ra[i], d, v);
      e = exp_rd_q.pop_front();
      n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
        $display("FAIL stopall[%h]: got %h exp %h", ra[i], d, e); end
    end
    exp_cmd_q.push_back('{voice: 4'd3, start: 1'b0, addr: 32'h1000_0000, len: 24'hFFFFFF,
                          loop: 1'b1});
    exp_cmd_q.push_back('{voice: 4'd14, start: 1'b0, addr: 32'h0, len: 24'h0, loop: 1'b0});
    exp_cmd_q.push_back('{voice: 4'd15, start: 1'b0, addr: 32'hF000_0000, len: 24'h15, loop: 1'b0});
    exp_cmd_q.push_back('{voice: 4'd0, start: 1'b0, addr: 32'hA000_0000, len: 24'h20, loop: 1'b1});
    exp_cmd_q.push_back('{voice: 4'd1, start: 1'b0, addr: 32'hB000_0000, len: 24'h30, loop: 1'b0});
    cpu_write(10'h003, 32'h1);
    while (exp_cmd_q.size() > 0) begin
      wait_cmd(seen);
      ec = exp_cmd_q.pop_front();
      n_cmp++; if (!seen || cur_cmd() !== ec) begin n_fail++;
        $display("FAIL stopall_cmd: seen %b got %h exp %h", seen, cur_cmd(), ec); end
      if (seen) accept_cmd();
    end
    ra = '{10'h004, 10'h10F, 10'h103};
    re = '{32'h0, 32'h1, 32'h1};
    foreach (ra[i]) exp_rd_q.push_back(re[i]);
    foreach (ra[i]) begin
      cpu_read(ra[i], d, v);
      e = exp_rd_q.pop_front();
      n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
        $display("FAIL stopall_post[%h]: got %h exp %h", ra[i], d, e); end
    end
  endtask

  task automatic test_done_w1c();
    logic [31:0] d, e;
    logic        v;
    @(negedge clk);
    bus.done_valid = 1'b1; bus.done_voice = 4'd3;
    bus.reg_addr_wr = 10'h10F; bus.data_in = 32'h2; bus.data_wren = 1'b1;
    @(negedge clk);
    bus.done_valid = 1'b0; bus.data_wren = 1'b0;
    exp_rd_q.push_back(32'h2);
    exp_rd_q.push_back(32'h0);
    cpu_read(10'h10F, d, v);
    e = exp_rd_q.pop_front();
    n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
      $display("FAIL done_set_wins: got %h exp %h", d, e); end
    cpu_write(10'h10F, 32'h2);
    cpu_read(10'h10F, d, v);
    e = exp_rd_q.pop_front();
    n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
      $display("FAIL done_w1c: got %h exp %h", d, e); end
  endtask

  task automatic test_irq();
    logic [31:0] d, e;
    logic        v;
    cpu_write(10'h005, 32'h8);
    exp_rd_q.push_back(IrqEn ? 32'h8 : 32'hDEAD_DEAD);
    cpu_read(10'h005, d, v);
    e = exp_rd_q.pop_front();
    n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
      $display("FAIL irq_mask_rd: got %h exp %h", d, e); end
    @(negedge clk);
    bus.done_valid = 1'b1; bus.done_voice = 4'd3;
    @(negedge clk);
    bus.done_valid = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b exp 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== IrqEn) begin n_fail++;
      $display("FAIL irq_set: got %b exp %b", irq, IrqEn); end
    cpu_write(10'h10F, 32'h2);
    n_cmp++; if (irq !== IrqEn) begin n_fail++;
      $display("FAIL irq_hold: got %b exp %b", irq, IrqEn); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b exp 0", irq); end
    @(negedge clk);
    bus.done_valid = 1'b1; bus.done_voice = 4'd4;
    @(negedge clk);
    bus.done_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b exp 0", irq); end
  endtask

  task automatic test_reset_mid_issue();
    logic [9:0]  ra[4];
    logic [31:0] re[4];
    logic [31:0] d, e;
    logic        v, seen;
    cmd_t        ec;
    exp_cmd_q.push_back('{voice: 4'd5, start: 1'b1, addr: 32'h0, len: 24'h0, loop: 1'b0});
    cpu_write(10'h116, 32'h1);
    wait_cmd(seen);
    ec = exp_cmd_q.pop_front();
    n_cmp++; if (!seen || cur_cmd() !== ec) begin n_fail++;
      $display("FAIL mid_cmd: seen %b got %h exp %h", seen, cur_cmd(), ec); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (bus.cmd_valid !== 1'b0 || cur_cmd() !== '0) begin n_fail++;
      $display("FAIL mid_reset_cmd: valid %b cmd %h exp 0/0", bus.cmd_valid, cur_cmd()); end
    ra = '{10'h117, 10'h003, 10'h004, 10'h10C};
    re = '{32'h0, 32'h0, 32'h0, 32'h0};
    foreach (ra[i]) exp_rd_q.push_back(re[i]);
    foreach (ra[i]) begin
      cpu_read(ra[i], d, v);
      e = exp_rd_q.pop_front();
      n_cmp++; if (v !== 1'b1 || d !== e) begin n_fail++;
        $display("FAIL mid_reset_rd[%h]: got %h exp %h", ra[i], d, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_start();
    test_rr_wrap();
    test_stop_wins();
    test_stop_all();
    test_done_w1c();
    test_irq();
    test_reset_mid_issue();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
